am25s_ser_tx: RTL

- Parallel-in/serial-out transmitter. It is the output-direction counterpart of the parallel capture registers in the AM29xx model library.
- It accepts a WIDTH-bit word into a holding register, then shifts the word out one bit per clock with a frame-valid strobe.
- The holding register and the shifter form a double buffer, so a second word can be queued while the first is shifting. This allows gapless back-to-back frames.
- Used as a serializer stage behind bitslice datapaths in the model collection.

---
 rtl/am25s_ser_pkg.sv | 21 ++
 rtl/am25s_ser_shreg.sv | 62 ++++++
 rtl/am25s_ser_tx.sv | 126 ++++++++++++
 3 files changed

// File: rtl/am25s_ser_pkg.sv
// Shared definitions for the am25s serial transmitter: FSM state codes and
// the counter-width helper.
package am25s_ser_pkg;

   // Two-state controller: waiting for a word, or shifting one out.
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   // Ceiling log2 with a floor of 1, so a 2-bit word still gets a 1-bit counter.
   function automatic int unsigned ser_clog2(input int unsigned value);
      int unsigned w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'd1 << i) < value) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/am25s_ser_shreg.sv
// Output shift register. A load copies the word in. Each shift moves the word
// one place toward the output end and fills the vacated end with zero.
// After a full frame the register is therefore all zeros. That keeps the
// serial line low when idle without a separate clear.
module am25s_ser_shreg
   import am25s_ser_pkg::*;
#(
   parameter int WIDTH     = 6,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             clr_,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_d,
   output logic             o_bit
);

   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] w_sr_shifted;

   // Build the shifted word bit by bit; the far end takes a zero.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_fill
               assign w_sr_shifted[gi] = 1'b0;
            end else begin : g_move
               assign w_sr_shifted[gi] = r_sr[gi-1];
            end
         end else begin : g_lsb
            if (gi == WIDTH-1) begin : g_fill
               assign w_sr_shifted[gi] = 1'b0;
            end else begin : g_move
               assign w_sr_shifted[gi] = r_sr[gi+1];
            end
         end
      end
   endgenerate

   // The output end depends on the bit order.
   generate
      if (MSB_FIRST) begin : g_out_msb
         assign o_bit = r_sr[WIDTH-1];
      end else begin : g_out_lsb
         assign o_bit = r_sr[0];
      end
   endgenerate

   // Load has priority over shift; the controller never asserts both together.
   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) begin
         r_sr <= '0;
      end else if (i_load) begin
         r_sr <= i_d;
      end else if (i_shift) begin
         r_sr <= w_sr_shifted;
      end
   end

endmodule

// File: rtl/am25s_ser_tx.sv
// Parallel-in/serial-out transmitter with a double buffer.
// A holding register queues the next word while the shifter sends the current one.
// Back-to-back words are sent with no idle cycle between frames.
module am25s_ser_tx
   import am25s_ser_pkg::*;
#(
   parameter int WIDTH     = 6,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             clr_,
   input  logic [WIDTH-1:0] d,
   input  logic             ld,
   output logic             rdy,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_,
   output logic             sdo,
   output logic             sv,
   output logic             busy,
   output logic             done
);

   localparam int unsigned      CNT_W    = ser_clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_hold;
   logic             r_hold_full;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sv;
   logic             r_done;

   logic w_accept;
   logic w_start;
   logic w_last;
   logic w_reload;
   logic w_end;
   logic w_step;
   logic w_load_sr;
   logic w_shift_sr;
   logic w_bit;

   // Accept only while the holding register is empty, using the registered rdy.
   // A word freed on this edge cannot be replaced until the next one.
   assign w_accept   = ld & ~r_hold_full;
   assign w_start    = (r_state == ST_IDLE) & r_hold_full;
   assign w_last     = (r_state == ST_SHIFT) & (r_cnt == CNT_LAST);
   assign w_reload   = w_last & r_hold_full;
   assign w_end      = w_last & ~r_hold_full;
   assign w_step     = (r_state == ST_SHIFT) & (r_cnt != CNT_LAST);
   assign w_load_sr  = w_start | w_reload;
   // The final shift drains the last bit so the line falls to 0 with sv.
   assign w_shift_sr = w_step | w_end;

   am25s_ser_shreg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clk     (clk),
      .clr_    (clr_),
      .i_load  (w_load_sr),
      .i_shift (w_shift_sr),
      .i_d     (r_hold),
      .o_bit   (w_bit)
   );

   // Holding register: filled by an accepted load, emptied when the shifter takes it.
   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else if (w_accept) begin
         r_hold      <= d;
         r_hold_full <= 1'b1;
      end else if (w_load_sr) begin
         r_hold_full <= 1'b0;
      end
   end

   // Controller: start from idle when a word is queued, stop after a frame with no successor.
   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) begin
         r_state <= ST_IDLE;
      end else if (w_start) begin
         r_state <= ST_SHIFT;
      end else if (w_end) begin
         r_state <= ST_IDLE;
      end
   end

   // Bit counter: restarts on every word taken from the holding register.
   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) begin
         r_cnt <= '0;
      end else if (w_load_sr) begin
         r_cnt <= '0;
      end else if (w_step) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Frame strobe and end-of-transmission pulse.
   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) begin
         r_sv   <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_end;
         if (w_load_sr) begin
            r_sv <= 1'b1;
         end else if (w_end) begin
            r_sv <= 1'b0;
         end
      end
   end

   // The shifter's output end is itself a flop, so sdo is registered.
   assign sdo  = w_bit;
   assign sv   = r_sv;
   assign done = r_done;
   assign busy = (r_state == ST_SHIFT);
   assign rdy  = ~r_hold_full;
   assign q    = r_hold;
   assign q_   = ~r_hold;

endmodule
